// File: rtl/flex_counter_updn.sv
// Up/down flexible counter with parallel load, saturate/wrap mode, midpoint strobe
// and a saturating wrap-event counter; every output is registered.
module flex_counter_updn #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     dir,
  input  logic                     sat_mode,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     half_flag,
  output logic                     wrap_pulse,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO  = {NUM_CNT_BITS{1'b0}};
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE   = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_CNT_BITS:0]    MID_ONE   = {{NUM_CNT_BITS{1'b0}}, 1'b1};
  localparam logic [WRAP_CNT_BITS-1:0] WRAP_ZERO = {WRAP_CNT_BITS{1'b0}};
  localparam logic [WRAP_CNT_BITS-1:0] WRAP_ONE  = {{(WRAP_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [WRAP_CNT_BITS-1:0] WRAP_MAX  = {WRAP_CNT_BITS{1'b1}};

  logic [NUM_CNT_BITS-1:0]  count_r;
  logic                     rollover_r;
  logic                     half_r;
  logic                     wrap_pulse_r;
  logic [WRAP_CNT_BITS-1:0] wrap_count_r;

  logic [NUM_CNT_BITS-1:0]  term_s;
  logic [NUM_CNT_BITS-1:0]  start_s;
  logic [NUM_CNT_BITS:0]    mid_s;
  logic                     r_zero_s;
  logic [NUM_CNT_BITS-1:0]  next_count_s;
  logic                     write_s;
  logic                     wrap_s;
  logic                     next_rollover_s;
  logic                     next_half_s;

  // Terminal, restart and midpoint values for the current direction and period
  always_comb begin
    term_s   = dir ? CNT_ONE : rollover_val;
    start_s  = dir ? rollover_val : CNT_ONE;
    mid_s    = ({1'b0, rollover_val} + MID_ONE) >> 1;
    r_zero_s = (rollover_val == CNT_ZERO);
  end

  // Next-count selection: load beats enable; R=0 pins the count at zero
  always_comb begin
    next_count_s = count_r;
    write_s      = 1'b0;
    wrap_s       = 1'b0;
    if (load) begin
      write_s      = 1'b1;
      next_count_s = r_zero_s ? CNT_ZERO : load_val;
    end else if (count_enable) begin
      write_s = 1'b1;
      if (r_zero_s) begin
        next_count_s = CNT_ZERO;
      end else if ((count_r == CNT_ZERO) || (count_r > rollover_val)) begin
        next_count_s = start_s;
      end else if (count_r == term_s) begin
        if (sat_mode) begin
          next_count_s = count_r;
        end else begin
          next_count_s = start_s;
          wrap_s       = 1'b1;
        end
      end else if (dir) begin
        next_count_s = count_r - CNT_ONE;
      end else begin
        next_count_s = count_r + CNT_ONE;
      end
    end else begin
      next_count_s = count_r;
    end
    next_rollover_s = !r_zero_s && (next_count_s == term_s);
    next_half_s     = !r_zero_s && ({1'b0, next_count_s} == mid_s);
  end

  // State update; flags are only recomputed when the count is written
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      count_r      <= CNT_ZERO;
      rollover_r   <= 1'b0;
      half_r       <= 1'b0;
      wrap_pulse_r <= 1'b0;
      wrap_count_r <= WRAP_ZERO;
    end else if (write_s) begin
      count_r      <= next_count_s;
      rollover_r   <= next_rollover_s;
      half_r       <= next_half_s;
      wrap_pulse_r <= wrap_s;
      if (wrap_s && (wrap_count_r != WRAP_MAX)) begin
        wrap_count_r <= wrap_count_r + WRAP_ONE;
      end
    end else begin
      wrap_pulse_r <= 1'b0;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = rollover_r;
  assign half_flag     = half_r;
  assign wrap_pulse    = wrap_pulse_r;
  assign wrap_count    = wrap_count_r;

endmodule

// File: tb/tb_flex_counter_updn.sv
// Scoreboard bench for flex_counter_updn: directed cycles push expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_flex_counter_updn;

  logic clk = 1'b0;
  logic n_rst = 1'b1, clear = 1'b0, count_enable = 1'b0, dir = 1'b0, sat_mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0, rollover_val = 4'd4;

  logic [3:0] cnt4, wc4;
  logic       rf4, hf4, wp4;
  logic [3:0] cnt2;
  logic [1:0] wc2;
  logic       rf2, hf2, wp2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sel;
    logic [3:0] cnt;
    logic       rf;
    logic       hf;
    logic       wp;
    logic [3:0] wc;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  flex_counter_updn #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable), .dir(dir),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .rollover_val(rollover_val),
    .count_out(cnt4), .rollover_flag(rf4), .half_flag(hf4), .wrap_pulse(wp4), .wrap_count(wc4)
  );

  flex_counter_updn #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable), .dir(dir),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .rollover_val(rollover_val),
    .count_out(cnt2), .rollover_flag(rf2), .half_flag(hf2), .wrap_pulse(wp2), .wrap_count(wc2)
  );

  exp_t       mon_e;
  string      mon_n;
  logic [3:0] mon_c, mon_wc;
  logic       mon_rf, mon_hf, mon_wp;

  // Monitor: compare the oldest expectation against the selected DUT after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = nm_q.pop_front();
      if (mon_e.sel) begin
        mon_c = cnt2; mon_rf = rf2; mon_hf = hf2; mon_wp = wp2; mon_wc = {2'b00, wc2};
      end else begin
        mon_c = cnt4; mon_rf = rf4; mon_hf = hf4; mon_wp = wp4; mon_wc = wc4;
      end
      checks++;
      if ({mon_c, mon_rf, mon_hf, mon_wp, mon_wc} !== {mon_e.cnt, mon_e.rf, mon_e.hf, mon_e.wp, mon_e.wc}) begin
        errors++;
        $display("FAIL %s got cnt=%0d rf=%0b hf=%0b wp=%0b wc=%0d want cnt=%0d rf=%0b hf=%0b wp=%0b wc=%0d",
                 mon_n, mon_c, mon_rf, mon_hf, mon_wp, mon_wc,
                 mon_e.cnt, mon_e.rf, mon_e.hf, mon_e.wp, mon_e.wc);
      end
    end
  end

  // One clock of stimulus plus the outputs expected after the following edge
  task automatic cyc(input logic nr, input logic clr, input logic ld, input logic en,
                     input logic [3:0] lv, input logic sel, input logic [3:0] ec,
                     input logic erf, input logic ehf, input logic ewp,
                     input logic [3:0] ewc, input string nm);
    exp_t e;
    @(negedge clk);
    n_rst = nr; clear = clr; load = ld; count_enable = en; load_val = lv;
    e.sel = sel; e.cnt = ec; e.rf = erf; e.hf = ehf; e.wp = ewp; e.wc = ewc;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  initial begin
    // Reset, then up-count with wrap, R=4 (M=2)
    rollover_val = 4'd4; dir = 1'b0; sat_mode = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, "up1");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd0, "up2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, "up3");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, "up4");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, "upwrap1");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd1, "up2b");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd1, "up3b");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'd1, "up4b");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd2, "upwrap2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, "up2c");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, "hold");
    @(negedge clk); rollover_val = 4'd10; dir = 1'b1; count_enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, "hold_r_dir_change");

    // Clear, then down-count R=10 (M=5)
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "clear");
    for (int v = 10; v >= 1; v--) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'(v), (v == 1), (v == 5), 1'b0, 4'd0, "down");
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b1, 4'd1, "downwrap");

    // Saturate mode R=6 (M=3)
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "clear2");
    @(negedge clk); rollover_val = 4'd6; dir = 1'b0; sat_mode = 1'b1; clear = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, (v > 6) ? 4'd6 : 4'(v), (v >= 6), (v == 3), 1'b0, 4'd0, "sat");
    end

    // Load priority and out-of-range load, R=8
    @(negedge clk); rollover_val = 4'd8; sat_mode = 1'b0; count_enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 4'd0, "load12");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, "oor_restart");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "clear_wins");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, "restart");
    @(negedge clk); rollover_val = 4'd0; count_enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "r0_enable");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "r0_load");

    // Wrap counter saturation on the 2-bit instance, R=1
    @(negedge clk); rollover_val = 4'd1; load = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "reset2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0, "r1_first");
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, (k > 3) ? 4'd3 : 4'(k), "wc_sat");
    end

    // Mid-run reset, R=5 (M=3), then direction changes at the terminals
    @(negedge clk); rollover_val = 4'd5; count_enable = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "reset3");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, "r5_1");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, "r5_2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, "r5_3");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, "midrun_reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, "resume");
    @(negedge clk); dir = 1'b1; count_enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 4'd1, "dir_down_wrap");
    @(negedge clk); dir = 1'b0; count_enable = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd2, "dir_up_wrap");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd2, "pulse_drops");

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
